// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared game-wide definitions: game FSM state encodings, pool
//               sizes, derived index widths and the lowest-free-slot priority
//               encoder used by the bullet schedulers.
// Contents    : game_state_e  - game FSM state encoding (3 bits)
//               MAX_*         - highest enemy / bullet indices
//               *_IDX_W       - index widths derived from the pool sizes
//               slot_sel_t    - {found, idx} result of the slot search
//               lowest_free_slot() - lowest clear bit of an occupancy map
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

   typedef enum logic [2:0] {
      GAME_IDLE    = 3'b000,
      GAME_PLAYING = 3'b001,
      GAME_VICTORY = 3'b010,
      GAME_DEFEAT  = 3'b011,
      GAME_ERROR   = 3'b100
   } game_state_e;

   localparam int MAX_ENEMY         = 15;
   localparam int MAX_ENEMY_BULLET  = 31;
   localparam int MAX_PLAYER_BULLET = 7;

   localparam int ENEMY_NUM     = MAX_ENEMY + 1;
   localparam int EBULLET_NUM   = MAX_ENEMY_BULLET + 1;
   localparam int ENEMY_IDX_W   = $clog2(ENEMY_NUM);
   localparam int EBULLET_IDX_W = $clog2(EBULLET_NUM);

   typedef struct packed {
      logic                     found;
      logic [EBULLET_IDX_W-1:0] idx;
   } slot_sel_t;

   // Scans from the top down so the final hit is the lowest clear bit.
   function automatic slot_sel_t lowest_free_slot(input logic [EBULLET_NUM-1:0] busy);
      slot_sel_t sel;
      sel.found = 1'b0;
      sel.idx   = '0;
      for (int i = EBULLET_NUM - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            sel.found = 1'b1;
            sel.idx   = EBULLET_IDX_W'(i);
         end
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Picks the first asserted
//               request at or after the pointer, wrapping N-1 -> 0.
// Ports       : req        in  N   request vector
//               ptr        in  IW  search start position
//               grant      out N   one-hot grant
//               grant_idx  out IW  encoded grant index (0 when none)
//               grant_any  out 1   at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N  = 16,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   always_comb begin
      int unsigned j;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = 0;
      for (int i = 0; i < N; i++) begin
         // Modulo keeps the wrap correct for non power-of-two N as well.
         j = (32'(ptr) + 32'(i)) % 32'(N);
         if (!grant_any && req[j]) begin
            grant_any = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/enemy_bullet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : enemy_bullet_scheduler
// Description : Grants at most one enemy per cycle a free slot of the enemy
//               bullet pool, with round-robin fairness among enemies and a
//               per-enemy frame cooldown. Slots are returned via release.
// Ports       : clk            in  1   system clock
//               rst            in  1   asynchronous active-high reset
//               game_state     in  3   game FSM state
//               frame_tick     in  1   one pulse per video frame
//               fire_req       in  16  per-enemy fire request (level)
//               enemy_alive    in  16  per-enemy alive flag
//               release_valid  in  1   free one slot this cycle
//               release_slot   in  5   slot to free
//               grant_valid    out 1   one-cycle grant pulse
//               grant_enemy    out 4   granted enemy (held between grants)
//               grant_slot     out 5   allocated slot (held between grants)
//               slot_busy      out 32  slot occupancy bitmap
//               busy_count     out 6   number of busy slots
//               pool_full      out 1   all slots busy
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_bullet_scheduler #(
   parameter  int         MAX_ENEMY        = 15,
   parameter  int         MAX_ENEMY_BULLET = 31,
   parameter  logic [7:0] FIRE_COOLDOWN    = 8'd60,
   localparam int         EW               = $clog2(MAX_ENEMY + 1),
   localparam int         SW               = $clog2(MAX_ENEMY_BULLET + 1),
   localparam int         CW               = $clog2(MAX_ENEMY_BULLET + 2)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                game_state,
   input  logic                      frame_tick,
   input  logic [MAX_ENEMY:0]        fire_req,
   input  logic [MAX_ENEMY:0]        enemy_alive,
   input  logic                      release_valid,
   input  logic [SW-1:0]             release_slot,
   output logic                      grant_valid,
   output logic [EW-1:0]             grant_enemy,
   output logic [SW-1:0]             grant_slot,
   output logic [MAX_ENEMY_BULLET:0] slot_busy,
   output logic [CW-1:0]             busy_count,
   output logic                      pool_full
);

   import game_pkg::*;

   localparam int NE = MAX_ENEMY + 1;
   localparam int NS = MAX_ENEMY_BULLET + 1;

   logic [7:0]    cooldown [NE];
   logic [EW-1:0] rr_ptr;

   logic          playing;
   logic          idle;
   logic [NE-1:0] eligible;
   logic [NE-1:0] arb_onehot;
   logic [EW-1:0] arb_idx;
   logic          arb_any;
   slot_sel_t     free_sel;
   logic          do_grant;
   logic          do_release;
   logic [NS-1:0] grant_mask;
   logic [NS-1:0] release_mask;
   logic [NS-1:0] busy_next;
   logic [CW-1:0] count_next;
   logic [EW-1:0] ptr_next;

   assign playing = (game_state == GAME_PLAYING);
   assign idle    = (game_state == GAME_IDLE);

   for (genvar i = 0; i < NE; i++) begin : g_eligible
      assign eligible[i] = fire_req[i] & enemy_alive[i] & (cooldown[i] == 8'd0);
   end

   // Gating the requests outside PLAYING keeps the arbiter itself generic.
   rr_arbiter #(.N(NE)) u_arb (
      .req       (eligible & {NE{playing}}),
      .ptr       (rr_ptr),
      .grant     (arb_onehot),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   // Search runs on pre-release occupancy: a slot freed this cycle becomes
   // grantable only from the next cycle.
   assign free_sel     = lowest_free_slot(slot_busy);
   assign do_grant     = arb_any & free_sel.found;
   assign do_release   = release_valid & slot_busy[release_slot];
   assign grant_mask   = do_grant   ? (NS'(1) << free_sel.idx)  : '0;
   assign release_mask = do_release ? (NS'(1) << release_slot)  : '0;
   assign busy_next    = (slot_busy & ~release_mask) | grant_mask;
   // The granted slot is free and the released slot is busy, so they never
   // collide and the count moves by +1 / -1 independently.
   assign count_next   = busy_count + CW'(do_grant) - CW'(do_release);
   assign ptr_next     = (arb_idx == EW'(MAX_ENEMY)) ? '0 : arb_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_valid <= 1'b0;
         grant_enemy <= '0;
         grant_slot  <= '0;
         slot_busy   <= '0;
         busy_count  <= '0;
         pool_full   <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         grant_valid <= do_grant;
         if (do_grant) begin
            grant_enemy <= arb_idx;
            grant_slot  <= free_sel.idx;
         end
         if (idle) begin
            slot_busy  <= '0;
            busy_count <= '0;
            pool_full  <= 1'b0;
            rr_ptr     <= '0;
         end else begin
            slot_busy  <= busy_next;
            busy_count <= count_next;
            pool_full  <= (count_next == CW'(NS));
            if (do_grant) begin
               rr_ptr <= ptr_next;
            end
         end
      end
   end

   // A grant reload takes priority over a same-cycle frame decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NE; i++) begin
            cooldown[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NE; i++) begin
            if (idle) begin
               cooldown[i] <= 8'd0;
            end else if (do_grant && arb_onehot[i]) begin
               cooldown[i] <= FIRE_COOLDOWN;
            end else if (frame_tick && (cooldown[i] != 8'd0)) begin
               cooldown[i] <= cooldown[i] - 8'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_enemy_bullet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_bullet_scheduler
// Description : Self-checking bench. Two schedulers share one stimulus: A with
//               the default 60-frame cooldown, B with a zero cooldown. Both are
//               tracked by a slot/cooldown reference model; a vector table and
//               hand sequences add fixed expectations for the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_bullet_scheduler;
   import game_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  game_state = GAME_PLAYING;
   logic        frame_tick = 1'b0;
   logic [15:0] fire_req = '0;
   logic [15:0] enemy_alive = 16'hFFFF;
   logic        release_valid = 1'b0;
   logic [4:0]  release_slot = '0;

   logic        a_gv, b_gv;
   logic [3:0]  a_ge, b_ge;
   logic [4:0]  a_gs, b_gs;
   logic [31:0] a_sb, b_sb;
   logic [5:0]  a_cnt, b_cnt;
   logic        a_pf, b_pf;

   always #5 clk = ~clk;

   enemy_bullet_scheduler dut_a (
      .clk(clk), .rst(rst), .game_state(game_state), .frame_tick(frame_tick),
      .fire_req(fire_req), .enemy_alive(enemy_alive),
      .release_valid(release_valid), .release_slot(release_slot),
      .grant_valid(a_gv), .grant_enemy(a_ge), .grant_slot(a_gs),
      .slot_busy(a_sb), .busy_count(a_cnt), .pool_full(a_pf)
   );

   enemy_bullet_scheduler #(.FIRE_COOLDOWN(8'd0)) dut_b (
      .clk(clk), .rst(rst), .game_state(game_state), .frame_tick(frame_tick),
      .fire_req(fire_req), .enemy_alive(enemy_alive),
      .release_valid(release_valid), .release_slot(release_slot),
      .grant_valid(b_gv), .grant_enemy(b_ge), .grant_slot(b_gs),
      .slot_busy(b_sb), .busy_count(b_cnt), .pool_full(b_pf)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model (index 0 = A, 1 = B) ----------------
   int cool_of [2] = '{60, 0};
   int m_cd   [2][16];
   bit m_busy [2][32];
   int m_ptr  [2];
   bit m_gv   [2];
   int m_ge   [2];
   int m_gs   [2];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) m_cd[m][i] = 0;
         for (int s = 0; s < 32; s++) m_busy[m][s] = 1'b0;
         m_ptr[m] = 0; m_gv[m] = 1'b0; m_ge[m] = 0; m_gs[m] = 0;
      end
   endfunction

   function automatic int m_count(int m);
      int n = 0;
      for (int s = 0; s < 32; s++) n += int'(m_busy[m][s]);
      return n;
   endfunction

   function automatic logic [31:0] m_bits(int m);
      logic [31:0] v = '0;
      for (int s = 0; s < 32; s++) v[s] = m_busy[m][s];
      return v;
   endfunction

   // One clock edge of the scheduler rules, applied to the current inputs.
   function automatic void model_step();
      for (int m = 0; m < 2; m++) begin
         int  e = -1;
         int  s = -1;
         bit  rel;
         m_gv[m] = 1'b0;
         if (game_state == GAME_IDLE) begin
            for (int i = 0; i < 16; i++) m_cd[m][i] = 0;
            for (int k = 0; k < 32; k++) m_busy[m][k] = 1'b0;
            m_ptr[m] = 0;
         end else begin
            if (game_state == GAME_PLAYING) begin
               for (int k = 0; k < 16; k++) begin
                  int j = (m_ptr[m] + k) % 16;
                  if (e < 0 && fire_req[j] && enemy_alive[j] && m_cd[m][j] == 0) e = j;
               end
               for (int k = 31; k >= 0; k--) if (!m_busy[m][k]) s = k;
            end
            rel = release_valid && m_busy[m][release_slot];
            if (frame_tick)
               for (int i = 0; i < 16; i++) if (m_cd[m][i] > 0) m_cd[m][i]--;
            if (e >= 0 && s >= 0) begin
               m_cd[m][e] = cool_of[m];
               m_busy[m][s] = 1'b1;
               m_ptr[m] = (e + 1) % 16;
               m_gv[m] = 1'b1; m_ge[m] = e; m_gs[m] = s;
            end
            if (rel) m_busy[m][release_slot] = 1'b0;
         end
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(int m, logic gv, logic [3:0] ge, logic [4:0] gs,
                          logic [31:0] sb, logic [5:0] cnt, logic pf);
      string p = (m == 0) ? "A" : "B";
      chk({p, ".grant_valid"}, 64'(gv),  64'(m_gv[m]));
      chk({p, ".grant_enemy"}, 64'(ge),  64'(m_ge[m]));
      chk({p, ".grant_slot"},  64'(gs),  64'(m_gs[m]));
      chk({p, ".slot_busy"},   64'(sb),  64'(m_bits(m)));
      chk({p, ".busy_count"},  64'(cnt), 64'(m_count(m)));
      chk({p, ".pool_full"},   64'(pf),  64'(m_count(m) == 32));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      cmp_dut(0, a_gv, a_ge, a_gs, a_sb, a_cnt, a_pf);
      cmp_dut(1, b_gv, b_ge, b_gs, b_sb, b_cnt, b_pf);
   endtask

   task automatic drive(logic [2:0] gs, logic [15:0] fr, logic [15:0] al,
                        logic ft, logic rv, logic [4:0] rs);
      game_state = gs; fire_req = fr; enemy_alive = al;
      frame_tick = ft; release_valid = rv; release_slot = rs;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, " A.grant_valid"}, 64'(a_gv), 0);
      chk({tag, " A.grant_enemy"}, 64'(a_ge), 0);
      chk({tag, " A.grant_slot"},  64'(a_gs), 0);
      chk({tag, " A.slot_busy"},   64'(a_sb), 0);
      chk({tag, " A.busy_count"},  64'(a_cnt), 0);
      chk({tag, " A.pool_full"},   64'(a_pf), 0);
      chk({tag, " B.grant_valid"}, 64'(b_gv), 0);
      chk({tag, " B.slot_busy"},   64'(b_sb), 0);
      chk({tag, " B.busy_count"},  64'(b_cnt), 0);
   endtask

   // ---------------- vector table for DUT A ----------------
   typedef struct {
      logic [2:0]  gs;
      logic [15:0] fire;
      logic [15:0] alive;
      logic        rv;
      logic [4:0]  rs;
      logic        e_gv;
      logic [3:0]  e_ge;
      logic [4:0]  e_gs;
      logic [5:0]  e_cnt;
   } vec_t;

   function automatic vec_t mk(logic [2:0] gs, logic [15:0] fire, logic [15:0] alive,
                               logic rv, logic [4:0] rs, logic e_gv, logic [3:0] e_ge,
                               logic [4:0] e_gs, logic [5:0] e_cnt);
      vec_t v;
      v.gs = gs; v.fire = fire; v.alive = alive; v.rv = rv; v.rs = rs;
      v.e_gv = e_gv; v.e_ge = e_ge; v.e_gs = e_gs; v.e_cnt = e_cnt;
      return v;
   endfunction

   vec_t tbl [11];

   initial begin
      tbl[0]  = mk(GAME_PLAYING, 16'h0001, 16'hFFFF, 0, 5'd0,  1, 4'd0,  5'd0, 6'd1);
      tbl[1]  = mk(GAME_PLAYING, 16'h0001, 16'hFFFF, 0, 5'd0,  0, 4'd0,  5'd0, 6'd1);
      tbl[2]  = mk(GAME_PLAYING, 16'h0003, 16'hFFFF, 0, 5'd0,  1, 4'd1,  5'd1, 6'd2);
      tbl[3]  = mk(GAME_PLAYING, 16'h0003, 16'hFFFF, 1, 5'd0,  0, 4'd1,  5'd1, 6'd1);
      tbl[4]  = mk(GAME_PLAYING, 16'h0004, 16'hFFFB, 0, 5'd0,  0, 4'd1,  5'd1, 6'd1);
      tbl[5]  = mk(GAME_PLAYING, 16'h0004, 16'hFFFF, 0, 5'd0,  1, 4'd2,  5'd0, 6'd2);
      tbl[6]  = mk(GAME_PLAYING, 16'h8000, 16'hFFFF, 0, 5'd0,  1, 4'd15, 5'd2, 6'd3);
      tbl[7]  = mk(GAME_PLAYING, 16'h0000, 16'hFFFF, 1, 5'd20, 0, 4'd15, 5'd2, 6'd3);
      tbl[8]  = mk(GAME_DEFEAT,  16'hFFFF, 16'hFFFF, 1, 5'd1,  0, 4'd15, 5'd2, 6'd2);
      tbl[9]  = mk(GAME_IDLE,    16'hFFFF, 16'hFFFF, 0, 5'd0,  0, 4'd15, 5'd2, 6'd0);
      tbl[10] = mk(GAME_PLAYING, 16'hFFFF, 16'hFFFF, 0, 5'd0,  1, 4'd0,  5'd0, 6'd1);

      // ---- reset: outputs must clear without a clock edge ----
      #1 rst = 1'b1;
      #1 chk_all_zero("reset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // ---- table vectors ----
      for (int t = 0; t < 11; t++) begin
         drive(tbl[t].gs, tbl[t].fire, tbl[t].alive, 1'b0, tbl[t].rv, tbl[t].rs);
         step();
         chk($sformatf("vec%0d grant_valid", t), 64'(a_gv),  64'(tbl[t].e_gv));
         chk($sformatf("vec%0d grant_enemy", t), 64'(a_ge),  64'(tbl[t].e_ge));
         chk($sformatf("vec%0d grant_slot", t),  64'(a_gs),  64'(tbl[t].e_gs));
         chk($sformatf("vec%0d busy_count", t),  64'(a_cnt), 64'(tbl[t].e_cnt));
      end

      // ---- A: enemy 0 waits exactly 60 frame ticks ----
      drive(GAME_PLAYING, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 5'd0);
      for (int k = 0; k < 60; k++) begin
         step();
         chk($sformatf("cooldown tick%0d grant_valid", k), 64'(a_gv), 0);
      end
      frame_tick = 1'b0;
      step();
      chk("cooldown expired grant_valid", 64'(a_gv), 1);
      chk("cooldown expired grant_enemy", 64'(a_ge), 0);

      // ---- B: round-robin fill of the whole pool ----
      drive(GAME_IDLE, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 5'd0);
      step();
      drive(GAME_PLAYING, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 5'd0);
      for (int k = 0; k < 32; k++) begin
         step();
         chk($sformatf("rr%0d grant_valid", k), 64'(b_gv), 1);
         chk($sformatf("rr%0d grant_enemy", k), 64'(b_ge), 64'(k % 16));
         chk($sformatf("rr%0d grant_slot", k),  64'(b_gs), 64'(k));
      end
      step();
      chk("full grant_valid", 64'(b_gv), 0);
      chk("full pool_full",   64'(b_pf), 1);
      chk("full busy_count",  64'(b_cnt), 32);
      release_valid = 1'b1; release_slot = 5'd7;
      step();
      chk("full+release grant_valid", 64'(b_gv), 0);
      chk("full+release pool_full",   64'(b_pf), 0);
      chk("full+release slot7",       64'(b_sb[7]), 0);
      release_valid = 1'b0;
      step();
      chk("refill grant_valid", 64'(b_gv), 1);
      chk("refill grant_slot",  64'(b_gs), 7);
      chk("refill busy_count",  64'(b_cnt), 32);

      // ---- B: same-cycle release and grant ----
      drive(GAME_IDLE, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 5'd0);
      step();
      drive(GAME_PLAYING, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 5'd0);
      repeat (10) step();
      chk("ten grants busy_count", 64'(b_cnt), 10);
      release_valid = 1'b1; release_slot = 5'd3;
      step();
      chk("rel+grant grant_slot", 64'(b_gs), 10);
      chk("rel+grant busy_count", 64'(b_cnt), 10);
      fire_req = 16'h0000; release_slot = 5'd20;
      step();
      chk("idle release busy_count", 64'(b_cnt), 10);
      release_slot = 5'd3;
      step();
      chk("repeat release busy_count", 64'(b_cnt), 10);

      // ---- B: state gating (DEFEAT freezes grants, IDLE clears) ----
      drive(GAME_DEFEAT, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 5'd0);
      step();
      chk("defeat grant_valid", 64'(b_gv), 0);
      chk("defeat busy_count",  64'(b_cnt), 9);
      drive(GAME_IDLE, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 5'd0);
      step();
      chk("idle slot_busy",  64'(b_sb), 0);
      chk("idle busy_count", 64'(b_cnt), 0);
      game_state = GAME_PLAYING;
      step();
      chk("after idle grant_enemy", 64'(b_ge), 0);
      chk("after idle grant_slot",  64'(b_gs), 0);

      // ---- asynchronous reset in the middle of a grant burst ----
      repeat (3) step();
      #2 rst = 1'b1;
      #1 chk_all_zero("midreset");
      model_reset();
      @(negedge clk) rst = 1'b0;
      step();
      chk("post reset A.grant_valid", 64'(a_gv), 1);
      chk("post reset A.grant_enemy", 64'(a_ge), 0);
      chk("post reset A.grant_slot",  64'(a_gs), 0);

      // ---- randomized run against the model ----
      for (int k = 0; k < 800; k++) begin
         int unsigned r = $urandom_range(0, 99);
         logic [2:0] gs;
         if (r < 2)       gs = GAME_IDLE;
         else if (r < 86) gs = GAME_PLAYING;
         else             gs = 3'($urandom_range(2, 4));
         drive(gs, 16'($urandom) & 16'($urandom), 16'($urandom) | 16'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
               5'($urandom_range(0, 31)));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
